// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, parity modes and configuration limits
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int OS_MIN = 8;
  localparam int OS_MAX = 64;
  function automatic bit cfg_ok(input int data_bits, input int oversample, input int stop_bits);
    return data_bits >= DATA_BITS_MIN && data_bits <= DATA_BITS_MAX &&
           oversample >= OS_MIN && oversample <= OS_MAX && oversample % 2 == 0 &&
           (stop_bits == 1 || stop_bits == 2);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchroniser, per-bit tick counter and 3-sample majority vote
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic rx,
  input  logic clear,
  output logic rxs,
  output logic bit_val,
  output logic bit_done,
  output logic bit_end
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] C_LO = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] C_HI = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
  logic s1, smp0, smp1;
  logic [CW-1:0] cnt;
  assign bit_done = tick && cnt == C_HI;
  assign bit_end = tick && cnt == C_END;
  assign bit_val = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      smp0 <= 1'b1;
      smp1 <= 1'b1;
      cnt <= '0;
    end else begin
      {rxs, s1} <= {s1, rx};
      cnt <= clear ? '0 : tick ? (bit_end ? '0 : cnt + 1'b1) : cnt;
      if (tick && cnt == C_LO) smp0 <= rxs;
      if (tick && cnt == C_MID) smp1 <= rxs;
    end
  end
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with error reporting and valid/ready output
module uart_rx_param import uart_pkg::*; #(
  parameter int DATA_BITS = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
  if (!cfg_ok(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_bad_cfg
    $error("uart_rx_param: unsupported configuration");
  end
  uart_state_e state, state_nx;
  logic rxs, bit_val, bit_done, bit_end;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] bit_cnt;
  logic stop_cnt, par, ferr;
  logic last_data, deliver;
  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk(clk),
    .rst(rst),
    .tick(tick_i),
    .rx(rx),
    .clear(state == ST_IDLE),
    .rxs(rxs),
    .bit_val(bit_val),
    .bit_done(bit_done),
    .bit_end(bit_end)
  );
  assign last_data = bit_cnt == 4'(DATA_BITS - 1);
  assign deliver = state == ST_STOP && bit_done && stop_cnt == 1'(STOP_BITS - 1);
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   state_nx = rxs ? ST_IDLE : ST_START;
      ST_START:  state_nx = (bit_done && bit_val) ? ST_IDLE : bit_end ? ST_DATA : ST_START;
      ST_DATA:   state_nx = (bit_end && last_data) ? (PARITY_EN != 0 ? ST_PARITY : ST_STOP) : ST_DATA;
      ST_PARITY: state_nx = bit_end ? ST_STOP : ST_PARITY;
      ST_STOP:   state_nx = deliver ? ST_IDLE : ST_STOP;
      default:   state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      par <= 1'b0;
      ferr <= 1'b0;
      data_o <= '0;
      valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      busy_o <= state != ST_IDLE;
      overrun_o <= 1'b0;
      if (state == ST_IDLE) begin
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
        par <= 1'b0;
        ferr <= 1'b0;
      end
      if (state == ST_DATA && bit_done) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if ((state == ST_DATA || state == ST_PARITY) && bit_done) par <= par ^ bit_val;
      if (state == ST_DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
      if (state == ST_STOP && bit_done && !bit_val) ferr <= 1'b1;
      if (state == ST_STOP && bit_end) stop_cnt <= stop_cnt + 1'b1;
      if (deliver && (!valid_o || ready_i)) begin
        data_o <= shreg;
        parity_err_o <= PARITY_EN != 0 && par != PAR_MODE;
        frame_err_o <= ferr | !bit_val;
        valid_o <= 1'b1;
      end else begin
        overrun_o <= deliver;
        if (ready_i) valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param (8N1 and 8E1 instances)
module tb_uart_rx_param;
  typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clk, rst, tick, rx, rx_p, ready, ready_p;
  logic [7:0] data, data_p;
  logic valid, valid_p, perr, perr_p, ferr, ferr_p, ovr, ovr_p, busy, busy_p;
  exp_t q[$], qp[$];
  exp_t e, ep;
  int n_chk = 0, n_pass = 0, cyc = 0, start_cyc = 0, ovr_cnt = 0;
  logic seen;
  event frame_start;
  uart_rx_param dut (
    .clk(clk), .rst(rst), .tick_i(tick), .rx(rx), .data_o(data), .valid_o(valid),
    .ready_i(ready), .parity_err_o(perr), .frame_err_o(ferr), .overrun_o(ovr), .busy_o(busy)
  );
  uart_rx_param #(.PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .tick_i(tick), .rx(rx_p), .data_o(data_p), .valid_o(valid_p),
    .ready_i(ready_p), .parity_err_o(perr_p), .frame_err_o(ferr_p), .overrun_o(ovr_p), .busy_o(busy_p)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    else n_pass++;
  endtask
  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      if (q.size() == 0) chk("spurious_valid", 32'(valid), 0);
      else begin
        e = q.pop_front();
        chk("data", 32'(data), 32'(e.d));
        chk("parity_err", 32'(perr), 32'(e.pe));
        chk("frame_err", 32'(ferr), 32'(e.fe));
      end
    end
    if (!rst && valid_p && ready_p) begin
      if (qp.size() == 0) chk("spurious_valid_p", 32'(valid_p), 0);
      else begin
        ep = qp.pop_front();
        chk("data_p", 32'(data_p), 32'(ep.d));
        chk("parity_err_p", 32'(perr_p), 32'(ep.pe));
        chk("frame_err_p", 32'(ferr_p), 32'(ep.fe));
      end
    end
    if (ovr) ovr_cnt++;
  end
  task automatic drive(input int line, input logic v);
    if (line == 0) rx = v;
    else rx_p = v;
  endtask
  task automatic send(input int line, input logic [7:0] d, input bit par_en, input logic par_bit,
                      input logic stop_val, input int spike_bit, input int abort_bit);
    logic [11:0] f;
    int n;
    logic v;
    f = '0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    n = 9;
    if (par_en) begin
      f[n] = par_bit;
      n++;
    end
    f[n] = stop_val;
    n++;
    @(posedge clk);
    #1;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < 16; c++) begin
        v = f[b] ^ (b == spike_bit && c == 8);
        drive(line, v);
        if (b == 0 && c == 0) begin
          start_cyc = cyc + 1;
          ->frame_start;
        end
        if (b == abort_bit && c == 8) begin
          rst = 1'b1;
          drive(line, 1'b1);
          @(posedge clk);
          #1 rst = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
      end
    end
    drive(line, 1'b1);
    repeat (24) @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; tick = 1'b1; rx = 1'b1; rx_p = 1'b1; ready = 1'b1; ready_p = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(ovr), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_ferr", 32'(ferr), 0);
    repeat (5) @(posedge clk);
    q.push_back('{8'hA5, 1'b0, 1'b0});
    fork
      send(0, 8'hA5, 0, 0, 1, -1, -1);
      begin
        @(frame_start);
        for (int i = 0; i < 400 && !valid; i++) @(negedge clk);
        chk("latency", 32'(cyc - start_cyc), 156);
      end
    join
    q.push_back('{8'h55, 1'b0, 1'b1});
    send(0, 8'h55, 0, 0, 0, -1, -1);
    q.push_back('{8'h12, 1'b0, 1'b0});
    send(0, 8'h12, 0, 0, 1, -1, -1);
    @(posedge clk);
    #1 rx = 1'b0;
    seen = 1'b0;
    repeat (6) @(posedge clk);
    #1 rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen |= busy;
    end
    chk("glitch_busy_seen", 32'(seen), 1);
    chk("glitch_busy_idle", 32'(busy), 0);
    q.push_back('{8'h96, 1'b0, 1'b0});
    send(0, 8'h96, 0, 0, 1, 4, -1);
    ready = 1'b0;
    q.push_back('{8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 0, 0, 1, -1, -1);
    send(0, 8'h22, 0, 0, 1, -1, -1);
    chk("hold_data", 32'(data), 32'h11);
    chk("hold_valid", 32'(valid), 1);
    chk("overrun_once", 32'(ovr_cnt), 1);
    q.push_back('{8'h33, 1'b0, 1'b0});
    fork
      send(0, 8'h33, 0, 0, 1, -1, -1);
      begin
        @(frame_start);
        repeat (156) @(posedge clk);
        #1 ready = 1'b1;
      end
    join
    chk("no_overrun_on_load", 32'(ovr_cnt), 1);
    ready = 1'b0;
    send(0, 8'h5A, 0, 0, 1, -1, -1);
    send(0, 8'hC3, 0, 0, 1, 5, 5);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_data", 32'(data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_overrun", 32'(ovr), 0);
    chk("mid_rst_perr", 32'(perr), 0);
    chk("mid_rst_ferr", 32'(ferr), 0);
    ready = 1'b1;
    repeat (4) @(posedge clk);
    q.push_back('{8'h7E, 1'b0, 1'b0});
    send(0, 8'h7E, 0, 0, 1, -1, -1);
    qp.push_back('{8'h3C, 1'b1, 1'b0});
    send(1, 8'h3C, 1, 1, 1, -1, -1);
    qp.push_back('{8'h3C, 1'b0, 1'b0});
    send(1, 8'h3C, 1, 0, 1, -1, -1);
    qp.push_back('{8'h3D, 1'b0, 1'b0});
    send(1, 8'h3D, 1, 1, 1, -1, -1);
    q.push_back('{8'h00, 1'b0, 1'b1});
    q.push_back('{8'h00, 1'b0, 1'b0});
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (300) @(posedge clk);
    #1 rx = 1'b1;
    for (int i = 0; i < 500 && (q.size() != 0 || qp.size() != 0); i++) @(negedge clk);
    repeat (40) @(negedge clk);
    chk("drain_q", 32'(q.size()), 0);
    chk("drain_qp", 32'(qp.size()), 0);
    chk("overrun_total", 32'(ovr_cnt), 1);
    chk("final_busy", 32'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
